// File: rtl/shift_pkg.sv
// Shared types and stage-partitioning helpers for the pipelined shift expander.
package shift_pkg;

    typedef enum logic [1:0] {
        SHIFT_SLL = 2'b00,
        SHIFT_SRL = 2'b01,
        SHIFT_SRA = 2'b10,
        SHIFT_ROL = 2'b11
    } shift_op_e;

    // Mux layers handled by each stage; the last stage takes whatever is left.
    function automatic int layers_per_stage(input int shamt_w, input int pipe_stages);
        return (shamt_w + pipe_stages - 1) / pipe_stages;
    endfunction

    function automatic int stage_first_layer(input int shamt_w, input int pipe_stages,
                                             input int stage);
        int first;
        first = stage * layers_per_stage(shamt_w, pipe_stages);
        return (first < shamt_w) ? first : shamt_w;
    endfunction

    function automatic int stage_num_layers(input int shamt_w, input int pipe_stages,
                                            input int stage);
        int first;
        int lps;
        first = stage_first_layer(shamt_w, pipe_stages, stage);
        lps   = layers_per_stage(shamt_w, pipe_stages);
        return ((shamt_w - first) < lps) ? (shamt_w - first) : lps;
    endfunction

endpackage

// File: rtl/shift_pipe_stage.sv
// One register stage of the shift network: a run of power-of-two mux layers
// followed by the valid/data/op/shamt/tag registers and elastic ready logic.
module shift_pipe_stage
    import shift_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int SHAMT_W     = 7,
    parameter int TAG_W       = 4,
    parameter int FIRST_LAYER = 0,
    parameter int NUM_LAYERS  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_flush,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [2*DATA_W-1:0]   i_data,
    input  shift_op_e             i_op,
    input  logic [SHAMT_W-1:0]    i_shamt,
    input  logic [TAG_W-1:0]      i_tag,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [2*DATA_W-1:0]   o_data,
    output shift_op_e             o_op,
    output logic [SHAMT_W-1:0]    o_shamt,
    output logic [TAG_W-1:0]      o_tag
);

    localparam int FW = 2 * DATA_W;

    logic [FW-1:0]      w_layer [0:NUM_LAYERS];
    logic               r_valid;
    logic [FW-1:0]      r_data;
    shift_op_e          r_op;
    logic [SHAMT_W-1:0] r_shamt;
    logic [TAG_W-1:0]   r_tag;
    logic               w_ready;

    assign w_layer[0] = i_data;

    generate
        for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_layer
            localparam int AMT = 1 << (FIRST_LAYER + gi);
            // Rotation composes modulo the field width, so layers >= FW rotate by AMT % FW.
            localparam int ROT = AMT % FW;

            logic [FW-1:0] w_in;
            logic [FW-1:0] w_sll;
            logic [FW-1:0] w_srl;
            logic [FW-1:0] w_sra;
            logic [FW-1:0] w_rol;
            logic [FW-1:0] w_sel;

            assign w_in  = w_layer[gi];
            assign w_sll = w_in << AMT;
            assign w_srl = w_in >> AMT;
            assign w_sra = $signed(w_in) >>> AMT;

            if (ROT == 0) begin : g_rol_id
                assign w_rol = w_in;
            end else begin : g_rol_sh
                assign w_rol = (w_in << ROT) | (w_in >> (FW - ROT));
            end

            always_comb begin
                w_sel = w_in;
                case (i_op)
                    SHIFT_SLL: w_sel = w_sll;
                    SHIFT_SRL: w_sel = w_srl;
                    SHIFT_SRA: w_sel = w_sra;
                    SHIFT_ROL: w_sel = w_rol;
                    default:   w_sel = w_in;
                endcase
            end

            assign w_layer[gi+1] = i_shamt[FIRST_LAYER+gi] ? w_sel : w_in;
        end
    endgenerate

    assign w_ready = !r_valid || i_ready;
    assign o_ready = w_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_op    <= SHIFT_SLL;
            r_shamt <= '0;
            r_tag   <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (w_ready) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data  <= w_layer[NUM_LAYERS];
                r_op    <= i_op;
                r_shamt <= i_shamt;
                r_tag   <= i_tag;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_op    = r_op;
    assign o_shamt = r_shamt;
    assign o_tag   = r_tag;

endmodule

// File: rtl/shift_expander_pipe.sv
// Pipelined shift expander: places the operand in a 2*DATA_W field and shifts it
// through PIPE_STAGES elastic stages of log-depth mux layers.
module shift_expander_pipe
    import shift_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int SHAMT_W     = $clog2(2 * DATA_W) + 1,
    parameter int PIPE_STAGES = 2,
    parameter int TAG_W       = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_data,
    input  logic [SHAMT_W-1:0]    in_shamt,
    input  logic [1:0]            in_op,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*DATA_W-1:0]   out_data,
    output logic [TAG_W-1:0]      out_tag
);

    localparam int FW = 2 * DATA_W;

    logic               w_valid [0:PIPE_STAGES];
    logic               w_ready [0:PIPE_STAGES];
    logic [FW-1:0]      w_data  [0:PIPE_STAGES];
    shift_op_e          w_op    [0:PIPE_STAGES];
    logic [SHAMT_W-1:0] w_shamt [0:PIPE_STAGES];
    logic [TAG_W-1:0]   w_tag   [0:PIPE_STAGES];
    logic               w_unused_tail;

    assign w_op[0]    = shift_op_e'(in_op);
    assign w_valid[0] = in_valid;
    assign w_shamt[0] = in_shamt;
    assign w_tag[0]   = in_tag;

    // Left-going modes start from the low half, right-going modes from the high half.
    assign w_data[0] = (w_op[0] == SHIFT_SLL || w_op[0] == SHIFT_ROL)
                       ? {{DATA_W{1'b0}}, in_data}
                       : {in_data, {DATA_W{1'b0}}};

    assign w_ready[PIPE_STAGES] = out_ready;
    assign in_ready             = w_ready[0];

    generate
        for (genvar gi = 0; gi < PIPE_STAGES; gi++) begin : g_stage
            localparam int FIRST = stage_first_layer(SHAMT_W, PIPE_STAGES, gi);
            localparam int NUM   = stage_num_layers(SHAMT_W, PIPE_STAGES, gi);

            shift_pipe_stage #(
                .DATA_W      (DATA_W),
                .SHAMT_W     (SHAMT_W),
                .TAG_W       (TAG_W),
                .FIRST_LAYER (FIRST),
                .NUM_LAYERS  (NUM)
            ) u_stage (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_flush (flush),
                .i_valid (w_valid[gi]),
                .o_ready (w_ready[gi]),
                .i_data  (w_data[gi]),
                .i_op    (w_op[gi]),
                .i_shamt (w_shamt[gi]),
                .i_tag   (w_tag[gi]),
                .o_valid (w_valid[gi+1]),
                .i_ready (w_ready[gi+1]),
                .o_data  (w_data[gi+1]),
                .o_op    (w_op[gi+1]),
                .o_shamt (w_shamt[gi+1]),
                .o_tag   (w_tag[gi+1])
            );
        end
    endgenerate

    assign out_valid = w_valid[PIPE_STAGES];
    assign out_data  = w_data[PIPE_STAGES];
    assign out_tag   = w_tag[PIPE_STAGES];

    // Op and shamt are fully consumed by the last stage's layers.
    assign w_unused_tail = ^{w_shamt[PIPE_STAGES], w_op[PIPE_STAGES]};

endmodule

// File: tb/tb_shift_expander_pipe.sv
// Scoreboard bench for shift_expander_pipe: directed vectors, sweep, backpressure,
// reset/flush and randomized traffic against a plain-arithmetic reference model.
module tb_shift_expander_pipe;

    localparam int DW = 32;
    localparam int SW = 7;
    localparam int PS = 2;
    localparam int TW = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_data;
    logic [SW-1:0]   in_shamt;
    logic [1:0]      in_op;
    logic [TW-1:0]   in_tag;
    logic            out_valid;
    logic            out_ready;
    logic [2*DW-1:0] out_data;
    logic [TW-1:0]   out_tag;

    shift_expander_pipe #(
        .DATA_W      (DW),
        .SHAMT_W     (SW),
        .PIPE_STAGES (PS),
        .TAG_W       (TW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_op     (in_op),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2*DW-1:0] data;
        logic [TW-1:0]   tag;
        int              acc;
        bit              chk;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [2*DW-1:0] act, input logic [2*DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: shift the 64-bit placed field with ordinary operators.
    function automatic logic [2*DW-1:0] ref_model(input logic [DW-1:0] a, input logic [SW-1:0] s,
                                                 input logic [1:0] op);
        logic [2*DW-1:0] p;
        int r;
        case (op)
            2'b00: begin p = {{DW{1'b0}}, a}; return (s >= 2*DW) ? '0 : (p << s); end
            2'b01: begin p = {a, {DW{1'b0}}}; return (s >= 2*DW) ? '0 : (p >> s); end
            2'b10: begin
                p = {a, {DW{1'b0}}};
                if (s >= 2*DW) return {(2*DW){a[DW-1]}};
                return $signed(p) >>> s;
            end
            default: begin
                p = {{DW{1'b0}}, a};
                r = int'(s) % (2*DW);
                return (r == 0) ? p : ((p << r) | (p >> (2*DW - r)));
            end
        endcase
    endfunction

    // Drive one cycle at the falling edge; record the expectation if the input is taken.
    task automatic offer(input bit v, input logic [DW-1:0] d, input logic [SW-1:0] s,
                         input logic [1:0] op, input logic [TW-1:0] tag,
                         input logic [2*DW-1:0] exp, input bit chk, input bit ordy,
                         input bit fl, output bit acc);
        exp_t e;
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        in_shamt  = s;
        in_op     = op;
        in_tag    = tag;
        out_ready = ordy;
        flush     = fl;
        #1;
        acc = v && in_ready && !fl;
        if (acc) begin
            e.data = exp; e.tag = tag; e.acc = cyc; e.chk = chk;
            sb.push_back(e);
            $display("issue tag=%0d op=%0d shamt=%0d data=%h exp=%h", tag, op, s, d, exp);
        end
    endtask

    task automatic send(input logic [DW-1:0] d, input logic [SW-1:0] s, input logic [1:0] op,
                        input logic [TW-1:0] tag, input logic [2*DW-1:0] exp);
        bit acc;
        int n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 50) begin
            offer(1'b1, d, s, op, tag, exp, 1'b1, 1'b1, 1'b0, acc);
            n++;
        end
        if (!acc) check("send_timeout", 64'(acc), 64'd1);
    endtask

    task automatic idle(input int n, input bit ordy);
        bit acc;
        for (int i = 0; i < n; i++) offer(1'b0, '0, '0, 2'b00, '0, '0, 1'b0, ordy, 1'b0, acc);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            idle(1, 1'b1);
            #1;
            n++;
        end
        if (sb.size() != 0) check("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    // Monitor: pops and compares on every output transfer, and checks output holding.
    logic            prev_stall = 1'b0;
    logic            prev_flush = 1'b0;
    logic [2*DW-1:0] prev_data  = '0;
    logic [TW-1:0]   prev_tag   = '0;

    always @(negedge clk) begin
        exp_t e;
        #1;
        if (rst_n) begin
            if (prev_stall && !prev_flush) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_data", out_data, prev_data);
                check("hold_tag", 64'(out_tag), 64'(prev_tag));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_output: got data=%h tag=%0d, required no output",
                             out_data, out_tag);
                end else begin
                    e = sb.pop_front();
                    $display("result tag=%0d data=%h", out_tag, out_data);
                    check("result_data", out_data, e.data);
                    check("result_tag", 64'(out_tag), 64'(e.tag));
                    if (e.chk) check("latency", 64'(cyc - e.acc), 64'(PS));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_tag   = out_tag;
            prev_flush = flush;
            if (flush) sb.delete();
        end else begin
            prev_stall = 1'b0;
        end
    end

    localparam logic [DW-1:0] A = 32'h3AE51959;

    initial begin
        bit acc;
        int t;
        int accepts;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
        in_shamt = '0; in_op = 2'b00; in_tag = '0; out_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        #1 check("rst_in_ready", 64'(in_ready), 64'd1);

        // Directed vectors with constant expectations
        send(A,            7'd4,   2'b00, 4'd1,  64'h00000003_AE519590);
        send(A,            7'd8,   2'b01, 4'd2,  64'h003AE519_59000000);
        send(32'h80000001, 7'd4,   2'b10, 4'd3,  64'hF8000000_10000000);
        send(A,            7'd64,  2'b00, 4'd4,  64'h0);
        send(32'h80000000, 7'd100, 2'b10, 4'd5,  64'hFFFFFFFF_FFFFFFFF);
        send(A,            7'd36,  2'b11, 4'd6,  64'hAE519590_00000003);
        send(A,            7'd100, 2'b11, 4'd7,  64'hAE519590_00000003);
        send(A,            7'd0,   2'b00, 4'd8,  64'h00000000_3AE51959);
        send(A,            7'd0,   2'b01, 4'd9,  64'h3AE51959_00000000);
        send(A,            7'd0,   2'b10, 4'd10, 64'h3AE51959_00000000);
        send(A,            7'd0,   2'b11, 4'd11, 64'h00000000_3AE51959);
        send(A,            7'd70,  2'b01, 4'd12, 64'h0);
        send(32'h7FFFFFFF, 7'd127, 2'b10, 4'd13, 64'h0);
        drain();

        // SLL sweep 0..64, back to back
        for (int s = 0; s <= 64; s++) begin
            offer(1'b1, A, SW'(s), 2'b00, TW'(s), ref_model(A, SW'(s), 2'b00), 1'b1, 1'b1, 1'b0, acc);
            check("sweep_in_ready", 64'(acc), 64'd1);
        end
        drain();

        // Backpressure: 5 stalled cycles offering tags 1,2,3
        t = 1;
        accepts = 0;
        for (int i = 0; i < 5; i++) begin
            offer(1'b1, A + DW'(t), SW'(t), 2'b00, TW'(t), ref_model(A + DW'(t), SW'(t), 2'b00),
                  1'b0, 1'b0, 1'b0, acc);
            if (acc && t < 4) begin accepts++; t++; end
        end
        check("bp_accepts", 64'(accepts), 64'd2);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        for (int i = 0; i < 20 && t < 4; i++) begin
            offer(1'b1, A + DW'(t), SW'(t), 2'b00, TW'(t), ref_model(A + DW'(t), SW'(t), 2'b00),
                  1'b0, 1'b1, 1'b0, acc);
            if (acc) t++;
        end
        check("bp_all_accepted", 64'(t), 64'd4);
        drain();

        // Asynchronous reset with two ops in flight
        offer(1'b1, A, 7'd1, 2'b00, 4'd1, ref_model(A, 7'd1, 2'b00), 1'b0, 1'b0, 1'b0, acc);
        offer(1'b1, A, 7'd2, 2'b00, 4'd2, ref_model(A, 7'd2, 2'b00), 1'b0, 1'b0, 1'b0, acc);
        @(negedge clk);
        in_valid = 1'b0;
        #3 rst_n = 1'b0;
        sb.delete();
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_out_data", out_data, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(6, 1'b1);
        check("arst_in_ready", 64'(in_ready), 64'd1);

        // Flush with two ops in flight and a third offered in the flush cycle
        offer(1'b1, A, 7'd3, 2'b01, 4'd3, ref_model(A, 7'd3, 2'b01), 1'b0, 1'b0, 1'b0, acc);
        offer(1'b1, A, 7'd5, 2'b10, 4'd4, ref_model(A, 7'd5, 2'b10), 1'b0, 1'b0, 1'b0, acc);
        offer(1'b1, A, 7'd6, 2'b11, 4'd5, ref_model(A, 7'd6, 2'b11), 1'b0, 1'b0, 1'b1, acc);
        idle(1, 1'b0);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        idle(6, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [DW-1:0] d;
            logic [SW-1:0] s;
            logic [1:0]    op;
            d  = $urandom;
            s  = SW'($urandom_range(0, 127));
            op = 2'($urandom_range(0, 3));
            offer($urandom_range(0, 3) != 0, d, s, op, TW'(i), ref_model(d, s, op), 1'b0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0, acc);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/shift_expander_pipe.md
Name: shift_expander_pipe

Overview:
- Pipelined, parametrised successor to the combinational shift expander.
- Takes a DATA_W-bit operand and a shift amount, places the operand in a 2*DATA_W-bit field, and applies one of four shift modes through a log-depth mux network.
- The network is split across PIPE_STAGES register stages, with valid/ready handshakes on both sides.
- Feeds the core's multiply/divide and wide-shift datapaths, and tolerates downstream backpressure.

Parameters:
- DATA_W, 32: operand width; the result is 2*DATA_W bits.
- SHAMT_W, $clog2(2*DATA_W)+1: shift-amount width (7 when DATA_W=32).
- PIPE_STAGES, 2: number of register stages (1..SHAMT_W); this equals the latency in cycles.
- TAG_W, 4: width of the sideband tag carried alongside the data.

Ports:
- clk, in, 1: clock; all state updates on its rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- flush, in, 1: synchronous; discards all in-flight operations.
- in_valid, in, 1: input operation present.
- in_ready, out, 1: the block accepts the input this cycle.
- in_data, in, DATA_W: operand.
- in_shamt, in, SHAMT_W: shift amount (unsigned).
- in_op, in, 2: mode, shift_op_e.
- in_tag, in, TAG_W: sideband tag, passed through unchanged.
- out_valid, out, 1: result present.
- out_ready, in, 1: consumer accepts the result.
- out_data, out, 2*DATA_W: result.
- out_tag, out, TAG_W: tag of the result.

Behaviour:
- Reset (rst_n low, asynchronous): every stage valid bit = 0, out_valid = 0, out_data = 0, out_tag = 0, all internal data registers = 0.
  - Released state: in_ready = 1.
  - Reset mid-operation drops all in-flight work. No result is produced for it after release.
- Operand placement:
  - SLL and ROL: {DATA_W zeros, in_data}.
  - SRL and SRA: {in_data, DATA_W zeros}.
- Modes, applied over the 2W = 2*DATA_W field:
  - 00 SLL: logical left shift.
  - 01 SRL: logical right shift.
  - 10 SRA: arithmetic right shift, filled with in_data[DATA_W-1].
  - 11 ROL: rotate left by in_shamt mod 2W.
- Out-of-range shift amounts (in_shamt >= 2W):
  - SLL and SRL give 0.
  - SRA gives all sign bits.
  - ROL uses the amount modulo 2W.
- in_shamt = 0 gives the placed operand unchanged in every mode.
- Network structure:
  - One mux layer per shamt bit, LSB first.
  - Layers are assigned to stages in groups of ceil(SHAMT_W/PIPE_STAGES); the last stage takes the remainder.
  - Op, remaining shamt bits and tag travel with the data.
- Latency: an input accepted in cycle N appears on out_* in cycle N+PIPE_STAGES when there is no backpressure. Throughput is 1 per cycle.
- Handshake:
  - A transfer happens when valid && ready are both high.
  - Stage k loads when ready_k = !valid_k || ready_{k+1}; ready past the last stage is out_ready. This collapses bubbles.
  - in_ready = ready_0, combinational from stage state and out_ready.
  - out_valid/out_data/out_tag are held stable while out_valid && !out_ready.
  - The block holds PIPE_STAGES results at most. When full and stalled, in_ready = 0.
- flush:
  - Next edge: all valid bits = 0. Data registers keep their values (don't care).
  - An input offered in the flush cycle is discarded, but in_ready still follows the normal rule.
  - Flush takes priority over both loading and holding.
- Simultaneous events:
  - Output pop and input push in the same cycle on a full pipe are both accepted.
  - Ordering is strictly FIFO.
- Illegal conditions: none; every in_op value is defined.

Decomposition:
- Package shift_pkg:
  - shift_op_e enum {SHIFT_SLL=2'b00, SHIFT_SRL=2'b01, SHIFT_SRA=2'b10, SHIFT_ROL=2'b11}.
  - A function layers_per_stage(SHAMT_W, PIPE_STAGES).
- Sub-module shift_pipe_stage:
  - Parametrised by DATA_W, FIRST_LAYER and NUM_LAYERS.
  - Holds the mux layers plus the valid/data/op/shamt/tag registers and its ready logic.
  - The top generate-instantiates PIPE_STAGES of them and does operand placement.

Test Plan:
- SLL, in_data=0x3AE51959, shamt=4, out_ready=1 -> out_data=0x00000003_AE519590, 2 cycles after acceptance; tag is echoed.
- SRL shamt=8 on 0x3AE51959 -> 0x003AE519_59000000. SRA shamt=4 on 0x80000001 -> 0xF8000000_10000000.
- Boundaries:
  - SLL shamt=64 -> 0.
  - SRA shamt=100 on 0x80000000 -> 0xFFFFFFFF_FFFFFFFF.
  - ROL shamt=36 and shamt=100 on 0x3AE51959 -> 0xAE519590_00000003 both.
  - shamt=0 in all modes -> placed operand.
- Sweep:
  - SLL shamt 0..64 back-to-back on 0x3AE51959.
  - Expect one result per cycle, matching the reference model {32'b0,a}<<s.
  - in_ready stays 1 throughout.
- Backpressure: out_ready=0 for 5 cycles with in_valid=1 continuously and tags 1,2,3 -> in_ready falls after 2 accepts. out_data is stable. On release, tags 1,2,3 emerge in order with no loss or duplication.
- Reset/flush:
  - Drop rst_n asynchronously with 2 ops in flight -> out_valid=0 and out_data=0 immediately. No stale result after release.
  - Repeat with flush=1 for one cycle -> out_valid=0 next cycle, in_ready=1.
